// File: rtl/alu_pkg.sv
// alu_pkg
// Shared definitions for the multicycle execute unit and the ALU control
// decoder that feeds it: the 4-bit operation codes, the multiply step
// count and the execute-unit state encoding.
package alu_pkg;

    localparam logic [3:0] OP_ADD     = 4'b0000;
    localparam logic [3:0] OP_AND     = 4'b0001;
    localparam logic [3:0] OP_LUI     = 4'b0010;
    localparam logic [3:0] OP_NOR     = 4'b0011;
    localparam logic [3:0] OP_OR      = 4'b0100;
    localparam logic [3:0] OP_SLL     = 4'b0101;
    localparam logic [3:0] OP_SRL     = 4'b0110;
    localparam logic [3:0] OP_SUB     = 4'b0111;
    localparam logic [3:0] OP_MUL     = 4'b1000;
    localparam logic [3:0] OP_ILLEGAL = 4'b1111;

    // One shift-add step per multiplier bit.
    localparam int MUL_STEPS = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_MUL,
        ST_DONE
    } state_t;

endpackage

// File: rtl/alu_multicycle_unit_multiplier.sv
// shift_add_multiplier
// Unsigned shift-add multiplier producing the low WIDTH bits of the product.
// One multiplier bit is consumed per cycle over MUL_STEPS cycles.
// Ports:
//   clk, reset            clock and asynchronous active-high reset
//   start                 load operands and begin (ignored while busy)
//   multiplicand          operand A
//   multiplier            operand B
//   busy                  steps remain
//   done                  this cycle performs the final step
//   product               accumulator value after this cycle's step
//                         (the final product when done is high)
module shift_add_multiplier
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [5:0]       count;

    // The product output already includes the current step, so the caller can
    // capture it on the same edge as the final step without an extra cycle.
    always_comb begin
        product = mplier[0] ? acc + mcand : acc;
        busy    = (count != 6'd0);
        done    = (count == 6'd1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= 6'd0;
        end else if (start && !busy) begin
            mcand  <= multiplicand;
            mplier <= multiplier;
            acc    <= '0;
            count  <= 6'(MUL_STEPS);
        end else if (busy) begin
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count - 6'd1;
        end
    end

endmodule

// File: rtl/alu_multicycle_unit.sv
// alu_multicycle_unit
// Multicycle execute unit. Logic ops, LUI and add/sub finish in one cycle,
// shifts iterate one bit per cycle and multiply uses the shift-add engine.
// Ports:
//   clk, reset                  clock and asynchronous active-high reset
//   in_valid / in_ready         request handshake (ready only in IDLE)
//   alu_operation, a, b         op code and operands
//   out_valid / out_ready       result handshake (result held until taken)
//   result, zero, illegal       registered result, result==0, bad op code
module alu_multicycle_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_operation,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
);

    state_t           state, state_next;
    logic [WIDTH-1:0] work, work_next;
    logic [4:0]       count, count_next;
    logic             shift_left, shift_left_next;
    logic [WIDTH-1:0] result_next;
    logic             zero_next;
    logic             illegal_next;
    logic [WIDTH-1:0] single_result;
    logic [WIDTH-1:0] shifted;
    logic             mul_start;
    logic             mul_busy;
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;

    shift_add_multiplier #(.WIDTH(WIDTH)) u_multiplier (
        .clk          (clk),
        .reset        (reset),
        .start        (mul_start),
        .multiplicand (a),
        .multiplier   (b),
        .busy         (mul_busy),
        .done         (mul_done),
        .product      (mul_product)
    );

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);

    // Single-cycle datapath and the one-bit shifter step.
    always_comb begin
        single_result = '0;
        case (alu_operation)
            OP_ADD:  single_result = a + b;
            OP_AND:  single_result = a & b;
            OP_LUI:  single_result = {b[19:0], 12'b0};
            OP_NOR:  single_result = ~(a | b);
            OP_OR:   single_result = a | b;
            OP_SUB:  single_result = a - b;
            default: single_result = '0;
        endcase
        shifted = shift_left ? (work << 1) : (work >> 1);
    end

    // Next-state logic. Result, zero and illegal only change when an operation
    // completes, so nothing partial is ever visible.
    always_comb begin
        state_next      = state;
        work_next       = work;
        count_next      = count;
        shift_left_next = shift_left;
        result_next     = result;
        illegal_next    = illegal;
        mul_start       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    case (alu_operation)
                        OP_ADD, OP_AND, OP_LUI, OP_NOR, OP_OR, OP_SUB: begin
                            result_next  = single_result;
                            illegal_next = 1'b0;
                            state_next   = ST_DONE;
                        end
                        OP_SLL, OP_SRL: begin
                            shift_left_next = (alu_operation == OP_SLL);
                            if (b[4:0] == 5'd0) begin
                                result_next  = a;
                                illegal_next = 1'b0;
                                state_next   = ST_DONE;
                            end else begin
                                work_next  = a;
                                count_next = b[4:0];
                                state_next = ST_SHIFT;
                            end
                        end
                        OP_MUL: begin
                            mul_start  = 1'b1;
                            state_next = ST_MUL;
                        end
                        default: begin
                            result_next  = '0;
                            illegal_next = 1'b1;
                            state_next   = ST_DONE;
                        end
                    endcase
                end
            end
            ST_SHIFT: begin
                work_next  = shifted;
                count_next = count - 5'd1;
                if (count == 5'd1) begin
                    result_next  = shifted;
                    illegal_next = 1'b0;
                    state_next   = ST_DONE;
                end
            end
            ST_MUL: begin
                // An idle engine here would mean a lost start; finishing
                // keeps the unit from hanging the pipeline.
                if (mul_done || !mul_busy) begin
                    result_next  = mul_product;
                    illegal_next = 1'b0;
                    state_next   = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        zero_next = (result_next == '0);
    end

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            work       <= '0;
            count      <= 5'd0;
            shift_left <= 1'b0;
            result     <= '0;
            zero       <= 1'b1;
            illegal    <= 1'b0;
        end else begin
            state      <= state_next;
            work       <= work_next;
            count      <= count_next;
            shift_left <= shift_left_next;
            result     <= result_next;
            zero       <= zero_next;
            illegal    <= illegal_next;
        end
    end

endmodule

// File: tb/tb_alu_multicycle_unit.sv
// tb_alu_multicycle_unit
// Self-checking bench for alu_multicycle_unit: directed cases followed by
// random operations, each compared against an arithmetic reference model
// for result, zero, illegal and latency, plus handshake behaviour.
module tb_alu_multicycle_unit;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_operation;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        illegal;

    int vectors;
    int miscompares;

    alu_multicycle_unit #(.WIDTH(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .alu_operation (alu_operation),
        .a             (a),
        .b             (b),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .result        (result),
        .zero          (zero),
        .illegal       (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: what each op code means arithmetically and how many
    // cycles it should take from accept to the first valid output.
    function automatic void model(input logic [3:0] op, input logic [31:0] x,
                                  input logic [31:0] y, output logic [31:0] r,
                                  output logic ill, output int lat);
        logic [63:0] full;
        ill = 1'b0;
        lat = 1;
        r   = 32'd0;
        case (op)
            4'd0: r = x + y;
            4'd1: r = x & y;
            4'd2: r = y << 12;
            4'd3: r = ~(x | y);
            4'd4: r = x | y;
            4'd5: begin r = x << y[4:0]; lat = 1 + int'(y[4:0]); end
            4'd6: begin r = x >> y[4:0]; lat = 1 + int'(y[4:0]); end
            4'd7: r = x - y;
            4'd8: begin
                full = {32'd0, x} * {32'd0, y};
                r    = full[31:0];
                lat  = 33;
            end
            default: begin r = 32'd0; ill = 1'b1; end
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Issue one op from a negedge, measure latency, check the result, hold it
    // under backpressure for 'hold' cycles, then release it while also
    // offering a new request that must not be taken on the release edge.
    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] x,
                                 input logic [31:0] y, input int hold);
        logic [31:0] exp_r;
        logic        exp_ill;
        int          exp_lat;
        int          lat;
        model(op, x, y, exp_r, exp_ill, exp_lat);
        checkOutput("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid      = 1'b1;
        alu_operation = op;
        a             = x;
        b             = y;
        @(posedge clk);
        lat = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        checkOutput("latency", 32'(lat), 32'(exp_lat));
        checkOutput("result", result, exp_r);
        checkOutput("zero", 32'(zero), 32'(exp_r == 32'd0));
        checkOutput("illegal", 32'(illegal), 32'(exp_ill));
        checkOutput("in_ready_done", 32'(in_ready), 32'd0);
        for (int h = 0; h < hold; h++) begin
            in_valid      = h[0];
            alu_operation = 4'd0;
            a             = $urandom;
            b             = $urandom;
            @(negedge clk);
            checkOutput("hold_valid", 32'(out_valid), 32'd1);
            checkOutput("hold_ready", 32'(in_ready), 32'd0);
            checkOutput("hold_result", result, exp_r);
            checkOutput("hold_zero", 32'(zero), 32'(exp_r == 32'd0));
        end
        out_ready     = 1'b1;
        in_valid      = 1'b1;
        alu_operation = 4'd0;
        a             = 32'd9;
        b             = 32'd9;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        checkOutput("release_valid", 32'(out_valid), 32'd0);
        checkOutput("release_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0]  op;
        logic [31:0] x;
        logic [31:0] y;
        vectors       = 0;
        miscompares   = 0;
        reset         = 1'b1;
        in_valid      = 1'b0;
        out_ready     = 1'b0;
        alu_operation = 4'd0;
        a             = 32'd0;
        b             = 32'd0;
        repeat (2) @(negedge clk);
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_result", result, 32'd0);
        checkOutput("reset_zero", 32'(zero), 32'd1);
        checkOutput("reset_illegal", 32'(illegal), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Directed cases.
        applyStimulus(4'd0, 32'd5, 32'd7, 0);
        applyStimulus(4'd7, 32'd3, 32'd3, 0);
        applyStimulus(4'd5, 32'd1, 32'd31, 0);
        applyStimulus(4'd6, 32'h8000_0000, 32'd0, 0);
        applyStimulus(4'd8, 32'hFFFF_FFFF, 32'd3, 0);
        applyStimulus(4'd8, 32'h0001_0000, 32'h0001_0000, 0);
        applyStimulus(4'd8, 32'd7, 32'd6, 0);
        applyStimulus(4'd2, 32'd0, 32'hABCD_E123, 0);
        applyStimulus(4'd3, 32'h0F0F_0000, 32'h00F0_00FF, 0);
        applyStimulus(4'd0, 32'h1234_5678, 32'h1111_1111, 10);
        applyStimulus(4'hF, 32'd55, 32'd66, 0);
        applyStimulus(4'd0, 32'd2, 32'd3, 0);
        applyStimulus(4'hC, 32'd1, 32'd1, 2);
        applyStimulus(4'd6, 32'hF000_0000, 32'd4, 1);

        // Reset in the middle of a multiply.
        in_valid      = 1'b1;
        alu_operation = 4'd8;
        a             = 32'd123;
        b             = 32'd456;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("abort_out_valid", 32'(out_valid), 32'd0);
        checkOutput("abort_in_ready", 32'(in_ready), 32'd1);
        checkOutput("abort_result", result, 32'd0);
        checkOutput("abort_zero", 32'(zero), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        applyStimulus(4'd0, 32'd1, 32'd1, 0);

        // Random operations.
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) op = 4'($urandom_range(9, 15));
            else                           op = 4'($urandom_range(0, 8));
            x = $urandom;
            y = $urandom;
            if ($urandom_range(0, 4) == 0) y = x;
            applyStimulus(op, x, y, int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
